// File: rtl/wb_master_port.sv
// wb_master_port: single-transfer Wishbone initiator with a one-deep request slot and ack timeout
module wb_master_port #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  input  logic [1:0]  sel_i,
  output logic        ready_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [1:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);
  typedef enum logic [1:0] {IDLE, CYCLE, RECOVER} state_t;
  state_t state, state_nx;
  logic pend_v, pend_we;
  logic [31:0] pend_adr, pend_dat;
  logic [1:0] pend_sel;
  logic [CNT_W-1:0] cnt;
  logic accept, ack_hit, to_hit, launch_pend, launch_req;
  assign ready_o = ~pend_v;
  assign accept = req_i & ~pend_v;
  assign ack_hit = (state == CYCLE) & wbm_ack_i;
  assign to_hit = (state == CYCLE) & ~wbm_ack_i & (cnt == CNT_W'(TIMEOUT - 1));
  assign launch_pend = (state == RECOVER) & pend_v;
  assign launch_req = accept & ((state == IDLE) | (state == RECOVER));
  // state register; reset drops the bus immediately
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_nx;
  // next state: launch from IDLE/RECOVER, leave CYCLE on ack or timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = launch_req ? CYCLE : IDLE;
      CYCLE:   state_nx = (ack_hit | to_hit) ? RECOVER : CYCLE;
      RECOVER: state_nx = (launch_pend | launch_req) ? CYCLE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // registered bus outputs, completion pulses, timeout counter and pending slot
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      rdata_o   <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      wbm_we_o  <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      cnt       <= '0;
      pend_v    <= 1'b0;
      pend_we   <= 1'b0;
      pend_adr  <= '0;
      pend_dat  <= '0;
      pend_sel  <= '0;
    end else begin
      done_o    <= ack_hit;
      err_o     <= to_hit;
      wbm_cyc_o <= state_nx == CYCLE;
      wbm_stb_o <= state_nx == CYCLE;
      if (ack_hit & ~wbm_we_o) rdata_o <= wbm_dat_i;
      cnt <= (launch_pend | launch_req) ? '0 : (state == CYCLE) ? cnt + 1'b1 : cnt;
      if (launch_pend) begin
        wbm_adr_o <= pend_adr;
        wbm_dat_o <= pend_dat;
        wbm_sel_o <= pend_sel;
        wbm_we_o  <= pend_we;
        pend_v    <= 1'b0;
      end else if (launch_req) begin
        wbm_adr_o <= adr_i;
        wbm_dat_o <= dat_i;
        wbm_sel_o <= sel_i;
        wbm_we_o  <= we_i;
      end else if ((state == CYCLE) & accept) begin
        pend_v   <= 1'b1;
        pend_we  <= we_i;
        pend_adr <= adr_i;
        pend_dat <= dat_i;
        pend_sel <= sel_i;
      end
    end
endmodule
